// File: rtl/ip_tx.sv
// ip_tx: IPv4 transmit stage. Waits for a frame start, computes the IPv4
// header checksum over the latched addresses and length, then streams the
// 20-byte header followed by the UDP datagram read from a FWFT byte FIFO.
module ip_tx #(
  parameter logic [7:0]  TTL      = 8'h40,
  parameter bit          DF       = 1'b1,
  parameter logic [15:0] MIN_ULEN = 16'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [31:0] src_ip,
  input  logic [31:0] det_ip,
  input  logic [15:0] udp_len,
  output logic        fifo_rxen,
  input  logic [7:0]  fifo_rxd,
  output logic [7:0]  txd,
  output logic        tx_valid
);

  localparam logic [15:0] FLAGS = DF ? 16'h4000 : 16'h0000;
  localparam logic [7:0]  PROTO = 8'h11;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_LOAD, S_SUM, S_FOLD0, S_FOLD1, S_HEAD, S_WORK, S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] ident;
  logic [31:0] acc;
  logic [31:0] src_q;
  logic [31:0] det_q;
  logic [15:0] ulen;
  logic [15:0] tot_len;
  logic [15:0] csum;

  // Short datagrams are padded up to the minimum UDP length.
  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    clamp_len = (len < MIN_ULEN) ? MIN_ULEN : len;
  endfunction

  // One's-complement end-around carry fold of the 32-bit accumulator.
  function automatic logic [31:0] fold(input logic [31:0] a);
    fold = {16'h0000, a[15:0]} + {16'h0000, a[31:16]};
  endfunction

  // Header word fed into the checksum on SUM cycle idx.
  function automatic logic [15:0] sum_word(input logic [3:0] idx);
    case (idx)
      4'd0:    sum_word = 16'h4500;
      4'd1:    sum_word = tot_len;
      4'd2:    sum_word = ident;
      4'd3:    sum_word = FLAGS;
      4'd4:    sum_word = {TTL, PROTO};
      4'd5:    sum_word = src_q[31:16];
      4'd6:    sum_word = src_q[15:0];
      4'd7:    sum_word = det_q[31:16];
      4'd8:    sum_word = det_q[15:0];
      default: sum_word = 16'h0000;
    endcase
  endfunction

  // Header byte emitted on HEAD cycle idx, network byte order.
  function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
    case (idx)
      5'd0:    hdr_byte = 8'h45;
      5'd1:    hdr_byte = 8'h00;
      5'd2:    hdr_byte = tot_len[15:8];
      5'd3:    hdr_byte = tot_len[7:0];
      5'd4:    hdr_byte = ident[15:8];
      5'd5:    hdr_byte = ident[7:0];
      5'd6:    hdr_byte = FLAGS[15:8];
      5'd7:    hdr_byte = FLAGS[7:0];
      5'd8:    hdr_byte = TTL;
      5'd9:    hdr_byte = PROTO;
      5'd10:   hdr_byte = csum[15:8];
      5'd11:   hdr_byte = csum[7:0];
      5'd12:   hdr_byte = src_q[31:24];
      5'd13:   hdr_byte = src_q[23:16];
      5'd14:   hdr_byte = src_q[15:8];
      5'd15:   hdr_byte = src_q[7:0];
      5'd16:   hdr_byte = det_q[31:24];
      5'd17:   hdr_byte = det_q[23:16];
      5'd18:   hdr_byte = det_q[15:8];
      5'd19:   hdr_byte = det_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  // After two folds the accumulator holds the final 16-bit sum.
  assign csum = ~acc[15:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_WAIT;
      S_WAIT:  if (fs) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SUM;
      S_SUM:   if (cnt == 16'd8) state_nxt = S_FOLD0;
      S_FOLD0: state_nxt = S_FOLD1;
      S_FOLD1: state_nxt = S_HEAD;
      S_HEAD:  if (cnt == 16'd19) state_nxt = S_WORK;
      S_WORK:  if (cnt == ulen - 16'd1) state_nxt = S_DONE;
      S_DONE:  if (!fs) state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    fd        = (state == S_DONE);
    fifo_rxen = (state == S_WORK);
  end

  // Cycle counter, cleared on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= 16'h0000;
    else if (state != state_nxt) cnt <= 16'h0000;
    else if (state == S_SUM || state == S_HEAD || state == S_WORK)
      cnt <= cnt + 16'd1;
  end

  // Per-packet field capture; udp_len is only looked at in LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q   <= 32'h0;
      det_q   <= 32'h0;
      ulen    <= 16'h0;
      tot_len <= 16'h0;
    end else if (state == S_LOAD) begin
      src_q   <= src_ip;
      det_q   <= det_ip;
      ulen    <= clamp_len(udp_len);
      tot_len <= clamp_len(udp_len) + 16'd20;
    end
  end

  // Identification field, bumped once per completed packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ident <= 16'h0000;
    else if (state == S_WORK && state_nxt == S_DONE)
      ident <= ident + 16'd1;
  end

  // Checksum accumulator: cleared in LOAD, summed in SUM, folded twice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 32'h0;
    end else begin
      case (state)
        S_LOAD:  acc <= 32'h0;
        S_SUM:   acc <= acc + {16'h0000, sum_word(cnt[3:0])};
        S_FOLD0: acc <= fold(acc);
        S_FOLD1: acc <= fold(acc);
        default: acc <= acc;
      endcase
    end
  end

  // Registered output byte stream: header, then FIFO payload, else idle zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txd      <= 8'h00;
      tx_valid <= 1'b0;
    end else if (state == S_HEAD) begin
      txd      <= hdr_byte(cnt[4:0]);
      tx_valid <= 1'b1;
    end else if (state == S_WORK) begin
      txd      <= fifo_rxd;
      tx_valid <= 1'b1;
    end else begin
      txd      <= 8'h00;
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ip_tx.sv
// tb_ip_tx: directed, table-driven bench for ip_tx (default and DF=0/TTL=80).
module tb_ip_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fs_drv = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] src_ip = 32'hC0A80002;
  logic [31:0] det_ip = 32'hC0A80003;
  logic [15:0] udp_len = 16'd26;
  logic [15:0] fifo_ptr = 16'h0000;
  logic [7:0]  fifo_rxd;

  logic        fd1, rxen1, valid1;
  logic [7:0]  txd1;
  logic        fd2, rxen2, valid2;
  logic [7:0]  txd2;
  logic        fs1, fs2;
  logic        m_fd, m_rxen, m_valid;
  logic [7:0]  m_txd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign fs1 = fs_drv & ~sel;
  assign fs2 = fs_drv & sel;
  assign fifo_rxd = fifo_ptr[7:0] ^ 8'hA5;
  assign m_fd    = sel ? fd2    : fd1;
  assign m_rxen  = sel ? rxen2  : rxen1;
  assign m_valid = sel ? valid2 : valid1;
  assign m_txd   = sel ? txd2   : txd1;

  // FWFT FIFO model: next byte presented after each read edge.
  always @(posedge clk)
    if (rst && (rxen1 || rxen2)) fifo_ptr <= fifo_ptr + 16'd1;

  ip_tx dut1 (
    .clk(clk), .rst(rst), .fs(fs1), .fd(fd1), .src_ip(src_ip), .det_ip(det_ip),
    .udp_len(udp_len), .fifo_rxen(rxen1), .fifo_rxd(fifo_rxd), .txd(txd1), .tx_valid(valid1)
  );

  ip_tx #(.TTL(8'h80), .DF(1'b0), .MIN_ULEN(16'd8)) dut2 (
    .clk(clk), .rst(rst), .fs(fs2), .fd(fd2), .src_ip(src_ip), .det_ip(det_ip),
    .udp_len(udp_len), .fifo_rxen(rxen2), .fifo_rxd(fifo_rxd), .txd(txd2), .tx_valid(valid2)
  );

  typedef struct {
    logic [15:0] udp_len;
    bit          sel;
    bit          hold;
    int          ulen;
    logic [7:0]  hdr [20];
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Sends one packet described by vec[v] and checks latency, header,
  // payload, lengths, fd timing and the DONE/WAIT handshake.
  task automatic run_pkt(input int v);
    logic [7:0]  cap [$];
    logic [15:0] base;
    int          reads;
    int          first_n;
    int          perr;
    bit          gap;
    bit          got_fd;
    sel = vec[v].sel;
    @(negedge clk);
    udp_len = vec[v].udp_len;
    fs_drv  = 1'b1;
    base    = fifo_ptr;
    cap.delete();
    reads = 0; first_n = -1; gap = 0; got_fd = 0; perr = 0;
    for (int n = 0; n < 400 && !got_fd; n++) begin
      @(negedge clk);
      if (n == 0 && !vec[v].hold) fs_drv = 1'b0;
      if (n == 1) udp_len = 16'h0100;
      if (m_rxen) reads++;
      if (m_valid) begin
        if (first_n < 0) first_n = n;
        cap.push_back(m_txd);
      end else if (first_n >= 0) begin
        gap = 1;
      end
      if (m_fd) begin
        got_fd = 1;
        chk($sformatf("v%0d fd_with_last_byte", v), m_valid, 1);
      end
    end
    chk($sformatf("v%0d fd_seen", v), got_fd, 1);
    chk($sformatf("v%0d first_byte_latency", v), first_n, 13);
    chk($sformatf("v%0d valid_gap", v), gap, 0);
    chk($sformatf("v%0d valid_count", v), cap.size(), 20 + vec[v].ulen);
    chk($sformatf("v%0d fifo_reads", v), reads, vec[v].ulen);
    for (int i = 0; i < 20; i++)
      chk($sformatf("v%0d hdr[%0d]", v, i), (i < cap.size()) ? cap[i] : 8'hxx, vec[v].hdr[i]);
    for (int i = 0; i < vec[v].ulen; i++) begin
      logic [15:0] p;
      p = base + 16'(i);
      if (20 + i >= cap.size() || cap[20 + i] !== (p[7:0] ^ 8'hA5)) perr++;
    end
    chk($sformatf("v%0d payload_errors", v), perr, 0);
    if (vec[v].hold) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d hold_fd", v), m_fd, 1);
        chk($sformatf("v%0d hold_no_tx", v), {m_valid, m_rxen}, 0);
      end
      fs_drv = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d fd_cleared", v), m_fd, 0);
  endtask

  initial begin
    bit ok;
    int reads;

    vec[0].udp_len = 16'd26; vec[0].sel = 0; vec[0].hold = 0; vec[0].ulen = 26;
    vec[0].hdr = '{8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                   8'hB9, 8'h69, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'hC0, 8'hA8, 8'h00, 8'h03};
    vec[1].udp_len = 16'd26; vec[1].sel = 0; vec[1].hold = 1; vec[1].ulen = 26;
    vec[1].hdr = '{8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h11,
                   8'hB9, 8'h68, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'hC0, 8'hA8, 8'h00, 8'h03};
    vec[2].udp_len = 16'd4;  vec[2].sel = 0; vec[2].hold = 0; vec[2].ulen = 8;
    vec[2].hdr = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h02, 8'h40, 8'h00, 8'h40, 8'h11,
                   8'hB9, 8'h79, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'hC0, 8'hA8, 8'h00, 8'h03};
    vec[3].udp_len = 16'd26; vec[3].sel = 1; vec[3].hold = 0; vec[3].ulen = 26;
    vec[3].hdr = '{8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h11,
                   8'hB9, 8'h69, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'hC0, 8'hA8, 8'h00, 8'h03};

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk("rst txd1", txd1, 0);
    chk("rst valid1", valid1, 0);
    chk("rst rxen1", rxen1, 0);
    chk("rst fd1", fd1, 0);
    chk("rst outs2", {txd2, valid2, rxen2, fd2}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) run_pkt(v);

    // Asynchronous reset in the middle of the payload.
    sel = 1'b0;
    @(negedge clk);
    fs_drv = 1'b1;
    reads = 0; ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (m_rxen) reads++;
      if (reads == 10) ok = 1;
    end
    chk("mid_work_reached", ok, 1);
    chk("mid_work_valid", valid1, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst txd", txd1, 0);
    chk("async_rst valid", valid1, 0);
    chk("async_rst rxen", rxen1, 0);
    chk("async_rst fd", fd1, 0);
    fs_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("held_rst outs", {txd1, valid1, rxen1, fd1}, 0);
    @(negedge clk);
    rst = 1'b1;
    // First packet after reset must carry ident 0 again.
    run_pkt(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
